// File: rtl/cnn_pool_pkg.sv
// Shared types and default sizes for the column max-pool datapath.
package cnn_pool_pkg;
   localparam int POOL_DATA_WIDTH = 16;
   localparam int POOL_WINDOWS    = 12;
   localparam int POOL_MAP_COLS   = 12;

   typedef logic [POOL_DATA_WIDTH-1:0] column_t [POOL_WINDOWS];
endpackage

// File: rtl/pool_col_mem.sv
// Column storage: one synchronous write port, one asynchronous read port.
module pool_col_mem
   import cnn_pool_pkg::*;
#(
   parameter int DATA_WIDTH = POOL_DATA_WIDTH,
   parameter int WINDOWS    = POOL_WINDOWS,
   parameter int DEPTH      = 4,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata [WINDOWS],
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata [WINDOWS]
);
   logic [DATA_WIDTH-1:0] mem [DEPTH][WINDOWS];

   // Storage is deliberately left out of reset; the head is only meaningful with out_valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/pool_column_buffer.sv
// Show-ahead column FIFO between the pool stage and the next layer; tags map index/last, flags drops.
module pool_column_buffer
   import cnn_pool_pkg::*;
#(
   parameter int DATA_WIDTH = POOL_DATA_WIDTH,
   parameter int WINDOWS    = POOL_WINDOWS,
   parameter int DEPTH      = 4,
   parameter int MAP_COLS   = POOL_MAP_COLS,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = $clog2(DEPTH + 1),
   localparam int IW        = $clog2(MAP_COLS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_column [WINDOWS],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_column [WINDOWS],
   output logic [IW-1:0]         out_col_idx,
   output logic                  out_last,
   output logic [CW-1:0]         count,
   output logic                  full,
   output logic                  overflow
);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_nxt;
   logic          push, pop;

   assign full = (count == CW'(DEPTH));
   assign pop  = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full buffer can still accept.
   assign push = in_valid && (!full || pop);

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + CW'(1);
      else if (pop && !push) count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         out_col_idx <= '0;
         overflow    <= 1'b0;
      end else if (clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         out_col_idx <= '0;
         overflow    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr      <= rd_ptr + AW'(1);
            out_col_idx <= (out_col_idx == IW'(MAP_COLS - 1)) ? '0 : out_col_idx + IW'(1);
         end
         if (in_valid && !push) overflow <= 1'b1;
         count     <= count_nxt;
         out_valid <= (count_nxt != '0);
      end
   end

   assign out_last = out_valid && (out_col_idx == IW'(MAP_COLS - 1));

   pool_col_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .WINDOWS    (WINDOWS),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push && !clear),
      .waddr (wr_ptr),
      .wdata (in_column),
      .raddr (rd_ptr),
      .rdata (out_column)
   );
endmodule

// File: tb/tb_pool_column_buffer.sv
// Directed bench for pool_column_buffer: show-ahead timing, overflow, map indexing, clear and async reset.
module tb_pool_column_buffer;
   import cnn_pool_pkg::*;

   logic          clk = 1'b0;
   logic          rst, clear, in_valid, out_ready;
   column_t       in_col, out_col;
   logic          out_valid, out_last, full, overflow;
   logic [3:0]    out_col_idx;
   logic [2:0]    count;
   int            vec = 0;
   int            err = 0;

   always #5 clk = ~clk;

   pool_column_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_column   (in_col),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_column  (out_col),
      .out_col_idx (out_col_idx),
      .out_last    (out_last),
      .count       (count),
      .full        (full),
      .overflow    (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      if (obs !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_col(input string tag, input logic [15:0] base);
      for (int i = 0; i < POOL_WINDOWS; i++) chk(tag, 32'(out_col[i]), 32'(base + 16'(i)));
   endtask

   task automatic set_col(input logic [15:0] base);
      for (int i = 0; i < POOL_WINDOWS; i++) in_col[i] = base + 16'(i);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_col(16'h0);
      tick(); tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_idx", 32'(out_col_idx), 0);
      rst = 1'b1;
      tick();

      // single column, 1-cycle latency
      set_col(16'h0001); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_valid", 32'(out_valid), 1);
      chk("single_count", 32'(count), 1);
      chk("single_idx", 32'(out_col_idx), 0);
      chk_col("single_col", 16'h0001);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_pop_valid", 32'(out_valid), 0);
      chk("single_pop_count", 32'(count), 0);
      // ready while empty has no effect
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("empty_ready_count", 32'(count), 0);
      chk("empty_ready_idx", 32'(out_col_idx), 1);

      // fill and overflow
      for (int k = 0; k < 5; k++) begin
         set_col(16'h0100 + 16'(k)); in_valid = 1'b1;
         tick();
         if (k == 3) begin
            chk("fill_full", 32'(full), 1);
            chk("fill_ovf_pre", 32'(overflow), 0);
         end
      end
      in_valid = 1'b0;
      chk("fill_ovf", 32'(overflow), 1);
      chk("fill_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(out_valid), 1);
         chk("drain_head", 32'(out_col[0]), 32'h0100 + 32'(k));
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 0);
      chk("drain_ovf_sticky", 32'(overflow), 1);
      do_clear();
      chk("clear_ovf", 32'(overflow), 0);
      chk("clear_count", 32'(count), 0);
      chk("clear_idx", 32'(out_col_idx), 0);

      // push and pop while full
      for (int k = 0; k < 4; k++) begin
         set_col(16'h0200 + 16'(k)); in_valid = 1'b1;
         tick();
      end
      set_col(16'h0204); out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("pp_count", 32'(count), 4);
      chk("pp_full", 32'(full), 1);
      chk("pp_ovf", 32'(overflow), 0);
      for (int k = 1; k <= 4; k++) begin
         chk_col("pp_head", 16'h0200 + 16'(k));
         tick();
      end
      out_ready = 1'b0;
      chk("pp_empty", 32'(out_valid), 0);
      do_clear();

      // map indexing: 13 columns straight through
      out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 13; k++) begin
         set_col(16'h0300 + 16'(k));
         tick();
         chk("map_head", 32'(out_col[0]), 32'h0300 + 32'(k));
         chk("map_idx", 32'(out_col_idx), 32'(k % 12));
         chk("map_last", 32'(out_last), (k == 11) ? 1 : 0);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("map_empty", 32'(out_valid), 0);
      chk("map_idx_wrap", 32'(out_col_idx), 1);
      do_clear();

      // backpressure hold with pushes arriving
      set_col(16'h0400); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bp_count0", 32'(count), 1);
      for (int c = 0; c < 5; c++) begin
         if (c == 0 || c == 2) begin
            set_col(16'h0410 + 16'(c)); in_valid = 1'b1;
         end
         tick();
         in_valid = 1'b0;
         chk_col("bp_head", 16'h0400);
         chk("bp_idx", 32'(out_col_idx), 0);
      end
      chk("bp_count", 32'(count), 3);
      do_clear();

      // async reset mid-stream at count=3, idx=5
      out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_col(16'h0500 + 16'(k));
         tick();
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_col(16'h0600 + 16'(k)); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("ar_pre_count", 32'(count), 3);
      chk("ar_pre_idx", 32'(out_col_idx), 5);
      #3 rst = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 0);
      chk("ar_count", 32'(count), 0);
      chk("ar_ovf", 32'(overflow), 0);
      chk("ar_idx", 32'(out_col_idx), 0);
      tick();
      rst = 1'b1;
      set_col(16'h0700); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ar_post_valid", 32'(out_valid), 1);
      chk("ar_post_idx", 32'(out_col_idx), 0);
      chk_col("ar_post_col", 16'h0700);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
